multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the R/I-type RV32I datapath: fetch, decode, execute, writeback.
//  - Owns the PC and the instruction register (IR).
//  - Drives a request/grant/response instruction-memory handshake.
//  - Feeds IR fields to the combinational control decoder.
//  - Gates the decoder's reg-write onto the register file in WRITEBACK only.
//  - Sits between instruction memory and the control unit / regfile / ALU.
// ---------------------------------------------------------------------------

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/pc_reg.sv | 36 +++
 rtl/multicycle_sequencer.sv | 107 ++++++++++
 tb/tb_multicycle_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package rv32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_RSP  = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  localparam logic [6:0]  OPC_R   = 7'b0110011;
  localparam logic [6:0]  OPC_I   = 7'b0010011;
  localparam int unsigned PC_STEP = 4;

  // Only register-register and register-immediate ALU ops are supported.
  function automatic logic is_supported_opc(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_I);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: resets to RESET_PC, advances by PC_STEP when enabled.
module pc_reg
  import rv32_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next PC: step forward on enable; natural wrap at 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (inc_en_i) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for R/I-type RV32I.
// Owns the FSM, the instruction register and the retire counter; the PC
// lives in pc_reg.
module multicycle_sequencer
  import rv32_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int unsigned     OPCODE   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            halt_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  input  logic            reg_write_i,
  output logic [XLEN-1:0] pc_o,
  output logic            alu_en_o,
  output logic            reg_write_o,
  output logic            retire_o,
  output logic [31:0]     retire_cnt_o,
  output logic            busy_o,
  output logic            illegal_o
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic              illegal_q, illegal_d;
  logic [OPCODE-1:0] opcode;
  logic              in_wb;

  assign opcode = instr_q[OPCODE-1:0];
  assign in_wb  = (state_q == ST_WRITEBACK);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start_i)       state_d = ST_FETCH;
      ST_FETCH:     if (imem_gnt_i)    state_d = ST_WAIT_RSP;
      ST_WAIT_RSP:  if (imem_rvalid_i) state_d = ST_DECODE;
      ST_DECODE:    state_d = is_supported_opc(opcode) ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = halt_i ? ST_IDLE : ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // IR capture, retire counting and sticky illegal flag.
  always_comb begin
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    illegal_d    = illegal_q;
    if ((state_q == ST_WAIT_RSP) && imem_rvalid_i) begin
      instr_d = imem_rdata_i;
    end
    if (in_wb) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
    if ((state_q == ST_DECODE) && !is_supported_opc(opcode)) begin
      illegal_d = 1'b1;
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      retire_cnt_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
      illegal_q    <= illegal_d;
    end
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (in_wb),
    .pc_o     (pc_o)
  );

  assign imem_req_o   = (state_q == ST_FETCH);
  assign imem_addr_o  = pc_o;
  assign instr_o      = instr_q;
  assign alu_en_o     = (state_q == ST_EXECUTE);
  assign reg_write_o  = in_wb && reg_write_i;
  assign retire_o     = in_wb;
  assign retire_cnt_o = retire_cnt_q;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a transaction-level model
// tracks PC, retire count and per-instruction timing while the bench plays
// instruction memory with random grant/response delays.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, halt_i, imem_gnt_i, imem_rvalid_i, reg_write_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o, alu_en_o, reg_write_o, retire_o, busy_o, illegal_o;
  logic [31:0] imem_addr_o, instr_o, pc_o, retire_cnt_o;

  // Second instance with a PC that wraps on its first retirement.
  logic        w_start, w_halt, w_gnt, w_rvalid, w_rwi;
  logic [31:0] w_rdata;
  logic        w_req, w_alu, w_wr, w_retire, w_busy, w_illegal;
  logic [31:0] w_addr, w_instr, w_pc, w_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  multicycle_sequencer #(.XLEN(32), .RESET_PC(32'h0), .OPCODE(7)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .halt_i(halt_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
    .reg_write_i(reg_write_i), .pc_o(pc_o), .alu_en_o(alu_en_o),
    .reg_write_o(reg_write_o), .retire_o(retire_o), .retire_cnt_o(retire_cnt_o),
    .busy_o(busy_o), .illegal_o(illegal_o)
  );

  multicycle_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .OPCODE(7)) dut_wrap (
    .clk(clk), .rst(rst), .start_i(w_start), .halt_i(w_halt),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata), .instr_o(w_instr),
    .reg_write_i(w_rwi), .pc_o(w_pc), .alu_en_o(w_alu),
    .reg_write_o(w_wr), .retire_o(w_retire), .retire_cnt_o(w_cnt),
    .busy_o(w_busy), .illegal_o(w_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One legal instruction starting with the DUT in FETCH. Expected timing:
  // FETCH (1+gw) -> WAIT_RSP (1+rw) -> DECODE -> EXECUTE -> WRITEBACK.
  task automatic run_instr(input logic [31:0] ins, input int unsigned gw,
                           input int unsigned rw, input logic rwi, input logic hlt);
    for (int unsigned k = 0; k < gw; k++) begin
      imem_gnt_i = 1'b0;
      start_i    = 1'($urandom);
      halt_i     = 1'($urandom);
      check("req_hold",  {31'b0, imem_req_o}, 32'd1);
      check("addr_hold", imem_addr_o, exp_pc);
      check("wr_gate_f", {31'b0, reg_write_o}, 32'd0);
      tick();
    end
    check("req_gnt",  {31'b0, imem_req_o}, 32'd1);
    check("addr_gnt", imem_addr_o, exp_pc);
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'($urandom);   // same-cycle rvalid must be ignored
    imem_rdata_i  = $urandom;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    check("req_off", {31'b0, imem_req_o}, 32'd0);
    for (int unsigned k = 0; k < rw; k++) begin
      check("busy_wait", {31'b0, busy_o}, 32'd1);
      check("alu_wait",  {31'b0, alu_en_o}, 32'd0);
      tick();
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = ins;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    // DECODE
    check("ir_dec",     instr_o, ins);
    check("alu_dec",    {31'b0, alu_en_o}, 32'd0);
    check("retire_dec", {31'b0, retire_o}, 32'd0);
    tick();
    // EXECUTE
    check("alu_ex",    {31'b0, alu_en_o}, 32'd1);
    check("ir_ex",     instr_o, ins);
    check("wr_gate_x", {31'b0, reg_write_o}, 32'd0);
    check("retire_ex", {31'b0, retire_o}, 32'd0);
    reg_write_i = rwi;
    halt_i      = hlt;
    tick();
    // WRITEBACK
    check("retire_wb", {31'b0, retire_o}, 32'd1);
    check("wr_wb",     {31'b0, reg_write_o}, {31'b0, rwi});
    check("alu_wb",    {31'b0, alu_en_o}, 32'd0);
    check("ir_wb",     instr_o, ins);
    check("pc_wb",     pc_o, exp_pc);
    tick();
    exp_pc  = exp_pc + 32'd4;
    exp_cnt = exp_cnt + 32'd1;
    reg_write_i = 1'($urandom);
    halt_i      = 1'($urandom);
    check("pc_next",   pc_o, exp_pc);
    check("cnt_next",  retire_cnt_o, exp_cnt);
    check("retire_lo", {31'b0, retire_o}, 32'd0);
    check("busy_next", {31'b0, busy_o}, {31'b0, !hlt});
    check("req_next",  {31'b0, imem_req_o}, {31'b0, !hlt});
  endtask

  task automatic start_from_idle();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], (r[0] ? 7'b0110011 : 7'b0010011)};
  endfunction

  initial begin
    logic in_idle;
    logic hlt;
    rst = 1'b1; start_i = 0; halt_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    imem_rdata_i = 0; reg_write_i = 1'b1;
    w_start = 0; w_halt = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0; w_rwi = 0;
    exp_pc = 32'h0; exp_cnt = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // T1: reset state and idle without start
    check("rst_pc",      pc_o, 32'h0);
    check("rst_ir",      instr_o, 32'h0);
    check("rst_cnt",     retire_cnt_o, 32'h0);
    check("rst_illegal", {31'b0, illegal_o}, 32'd0);
    check("rst_retire",  {31'b0, retire_o}, 32'd0);
    check("rst_alu",     {31'b0, alu_en_o}, 32'd0);
    check("rst_wr",      {31'b0, reg_write_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      imem_gnt_i = 1'($urandom); imem_rvalid_i = 1'($urandom);
      tick();
      check("idle_pc",   pc_o, 32'h0);
      check("idle_req",  {31'b0, imem_req_o}, 32'd0);
      check("idle_busy", {31'b0, busy_o}, 32'd0);
    end
    imem_gnt_i = 0; imem_rvalid_i = 0;

    // T2: zero-wait ADD
    start_from_idle();
    run_instr(32'h002081B3, 0, 0, 1'b1, 1'b1);
    check("t2_pc",  pc_o, 32'd4);
    check("t2_cnt", retire_cnt_o, 32'd1);

    // T3: gnt delayed 3, rvalid delayed 2
    start_from_idle();
    run_instr(rand_legal(), 3, 2, 1'b1, 1'b0);

    // Random back-to-back / halted instruction stream
    in_idle = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (in_idle) start_from_idle();
      hlt = ($urandom_range(0, 3) == 0);
      run_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), hlt);
      in_idle = hlt;
      if (hlt) begin
        start_i = 1'b0;
        tick();
        check("halt_idle", {31'b0, busy_o}, 32'd0);
        check("halt_pc",   pc_o, exp_pc);
      end
    end
    if (!in_idle) begin
      // drain: finish one more instruction with halt
      run_instr(rand_legal(), 0, 0, 1'b0, 1'b1);
    end

    // T6: reset during WAIT_RSP, late rvalid ignored
    start_from_idle();
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h002081B3;
    tick();
    imem_rvalid_i = 1'b0;
    exp_pc = 32'h0; exp_cnt = 32'h0;
    check("t6_busy",   {31'b0, busy_o}, 32'd0);
    check("t6_ir",     instr_o, 32'h0);
    check("t6_retire", {31'b0, retire_o}, 32'd0);
    check("t6_pc",     pc_o, exp_pc);
    check("t6_cnt",    retire_cnt_o, exp_cnt);
    check("t6_req",    {31'b0, imem_req_o}, 32'd0);

    // One retirement before the trap, so PC/counter are nonzero
    start_from_idle();
    run_instr(rand_legal(), 1, 1, 1'b1, 1'b0);

    // T4: illegal branch opcode -> TRAP
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00000063;
    tick();
    imem_rvalid_i = 1'b0;
    check("t4_ir", instr_o, 32'h00000063);
    check("t4_illegal_dec", {31'b0, illegal_o}, 32'd0);
    reg_write_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("t4_illegal", {31'b0, illegal_o}, 32'd1);
      check("t4_busy",    {31'b0, busy_o}, 32'd0);
      check("t4_wr",      {31'b0, reg_write_o}, 32'd0);
      check("t4_alu",     {31'b0, alu_en_o}, 32'd0);
      check("t4_req",     {31'b0, imem_req_o}, 32'd0);
      check("t4_pc",      pc_o, exp_pc);
      check("t4_cnt",     retire_cnt_o, exp_cnt);
      start_i = 1'b1; imem_gnt_i = 1'($urandom); imem_rvalid_i = 1'($urandom);
      tick();
    end
    start_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_illegal", {31'b0, illegal_o}, 32'd0);
    check("t4_rst_ir",      instr_o, 32'h0);

    // T5: PC wrap on the high-reset-PC instance, halted at WRITEBACK
    check("t5_rst_pc", w_pc, 32'hFFFF_FFFC);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    check("t5_req",  {31'b0, w_req}, 32'd1);
    check("t5_addr", w_addr, 32'hFFFF_FFFC);
    w_gnt = 1'b1;
    tick();
    w_gnt = 1'b0;
    w_rvalid = 1'b1; w_rdata = 32'h002081B3;
    tick();
    w_rvalid = 1'b0;
    tick();
    w_halt = 1'b1; w_rwi = 1'b1;
    tick();
    check("t5_retire", {31'b0, w_retire}, 32'd1);
    check("t5_wr",     {31'b0, w_wr}, 32'd1);
    tick();
    w_halt = 1'b0;
    check("t5_pc",   w_pc, 32'h0);
    check("t5_busy", {31'b0, w_busy}, 32'd0);
    check("t5_req2", {31'b0, w_req}, 32'd0);
    check("t5_cnt",  w_cnt, 32'd1);
    tick();
    check("t5_idle", {31'b0, w_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
